// File: rtl/axi_slave_mux_r_pkg.sv
// Shared constants for the AXI read-channel slave multiplexer.
// Holds the address decode bit, the AXI BURST/RESP encodings and the
// ownership state enum used by axi_slave_mux_r.
package axi_mux_pkg;

  // Address bit that selects slave 0 (bit clear) or slave 1 (bit set)
  localparam int DECODE_BIT = 31;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  // IDLE: no burst outstanding; BUSY: at least one burst owned by sel
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mux_state_e;

  // Width of a counter that must reach max_out inclusive
  function automatic int cnt_width(input int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/axi_slave_mux_r_if.sv
// AXI read address + read data channel bundle.
// The "master" modport drives AR and RREADY; the "slave" modport drives
// ARREADY and the R payload.
interface axi_slave_mux_r_if #(
  parameter int DATA_WIDTH = 1024,
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 8,
  parameter int USER_WIDTH = 8
);
  logic [ID_WIDTH-1:0]   ar_id;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]            ar_len;
  logic [2:0]            ar_size;
  logic [1:0]            ar_burst;
  logic                  ar_lock;
  logic [3:0]            ar_cache;
  logic [2:0]            ar_prot;
  logic [3:0]            ar_qos;
  logic [3:0]            ar_region;
  logic [USER_WIDTH-1:0] ar_user;
  logic                  ar_valid;
  logic                  ar_ready;

  logic [ID_WIDTH-1:0]   r_id;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;
  logic                  r_last;
  logic [USER_WIDTH-1:0] r_user;
  logic                  r_valid;
  logic                  r_ready;

  modport master (
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi_mux_r_slice.sv
// Two-entry skid register for the R path of axi_slave_mux_r.
// Adds one cycle of latency, sustains one beat per cycle, and both the
// output payload and the upstream-facing ready come straight from flops.
module axi_mux_r_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         out_valid_r;
  logic         skid_valid_r;
  logic [W-1:0] out_data_r;
  logic [W-1:0] skid_data_r;

  // The skid entry only fills when the output is stalled, so an empty skid
  // is exactly the condition for accepting a new beat.
  assign in_ready  = ~skid_valid_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

  // Output stage refills from the skid first so beat order is preserved
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
      out_data_r   <= {W{1'b0}};
      skid_data_r  <= {W{1'b0}};
    end else if (!out_valid_r || out_ready) begin
      if (skid_valid_r) begin
        out_data_r   <= skid_data_r;
        out_valid_r  <= 1'b1;
        skid_valid_r <= 1'b0;
      end else begin
        out_data_r  <= in_data;
        out_valid_r <= in_valid;
      end
    end else if (in_valid && !skid_valid_r) begin
      skid_data_r  <= in_data;
      skid_valid_r <= 1'b1;
    end else begin
      skid_valid_r <= skid_valid_r;
    end
  end

endmodule

// File: rtl/axi_slave_mux_r.sv
// AXI read-channel multiplexer: one upstream master port, two downstream
// slaves selected by ARADDR[31].  Reads stay in order by letting only one
// slave own the R channel at a time; an AR to the other slave waits until
// every outstanding burst has completed.
// Build option: define AXI_MUX_R_RSLICE_EN to insert a skid register on the
// R path (one extra cycle of R latency, full throughput).
module axi_slave_mux_r
  import axi_mux_pkg::*;
#(
  parameter int DATA_WIDTH      = 1024,
  parameter int ADDR_WIDTH      = 64,
  parameter int ID_WIDTH        = 8,
  parameter int USER_WIDTH      = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  axi_slave_mux_r_if.slave  s2m,
  axi_slave_mux_r_if.master m0,
  axi_slave_mux_r_if.master m1
);
  localparam int CNT_W      = cnt_width(MAX_OUTSTANDING);
  localparam int DECODE_IDX = (ADDR_WIDTH > DECODE_BIT) ? DECODE_BIT : (ADDR_WIDTH - 1);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  // Packed R beat layout: {id, data, resp, last, user}
  localparam int R_W      = ID_WIDTH + DATA_WIDTH + 2 + 1 + USER_WIDTH;
  localparam int LAST_BIT = USER_WIDTH;
  localparam int RESP_LSB = USER_WIDTH + 1;
  localparam int DATA_LSB = USER_WIDTH + 3;
  localparam int ID_LSB   = DATA_LSB + DATA_WIDTH;

  mux_state_e       state_r;
  mux_state_e       state_nxt_s;
  logic             sel_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             out_en_r;

  logic             target_s;
  logic             busy_s;
  logic             ar_allow_s;
  logic             ar_accept_s;
  logic             r_last_hs_s;

  logic             r_dn_valid_s;
  logic             r_dn_ready_s;
  logic [R_W-1:0]   r_dn_bus_s;
  logic             r_up_valid_s;
  logic [R_W-1:0]   r_up_bus_s;

  assign target_s = s2m.ar_addr[DECODE_IDX];
  assign busy_s   = (state_r == ST_BUSY);

  // Holds every handshake output low from reset assertion until the first
  // clock after release, independent of any downstream ready.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      out_en_r <= 1'b0;
    end else begin
      out_en_r <= 1'b1;
    end
  end

  // AR admission: room for another burst and no change of owning slave
  always_comb begin
    ar_allow_s = 1'b0;
    if (out_en_r && (cnt_r < CNT_MAX)) begin
      if (state_r == ST_IDLE) begin
        ar_allow_s = 1'b1;
      end else if (target_s == sel_r) begin
        ar_allow_s = 1'b1;
      end else begin
        ar_allow_s = 1'b0;
      end
    end else begin
      ar_allow_s = 1'b0;
    end
  end

  assign m0.ar_valid   = s2m.ar_valid & ar_allow_s & ~target_s;
  assign m1.ar_valid   = s2m.ar_valid & ar_allow_s &  target_s;
  assign s2m.ar_ready  = ar_allow_s & (target_s ? m1.ar_ready : m0.ar_ready);
  assign ar_accept_s   = s2m.ar_valid & s2m.ar_ready;

  // AR payload goes to both slaves; only the valids are steered
  assign m0.ar_id     = s2m.ar_id;
  assign m0.ar_addr   = s2m.ar_addr;
  assign m0.ar_len    = s2m.ar_len;
  assign m0.ar_size   = s2m.ar_size;
  assign m0.ar_burst  = s2m.ar_burst;
  assign m0.ar_lock   = s2m.ar_lock;
  assign m0.ar_cache  = s2m.ar_cache;
  assign m0.ar_prot   = s2m.ar_prot;
  assign m0.ar_qos    = s2m.ar_qos;
  assign m0.ar_region = s2m.ar_region;
  assign m0.ar_user   = s2m.ar_user;
  assign m1.ar_id     = s2m.ar_id;
  assign m1.ar_addr   = s2m.ar_addr;
  assign m1.ar_len    = s2m.ar_len;
  assign m1.ar_size   = s2m.ar_size;
  assign m1.ar_burst  = s2m.ar_burst;
  assign m1.ar_lock   = s2m.ar_lock;
  assign m1.ar_cache  = s2m.ar_cache;
  assign m1.ar_prot   = s2m.ar_prot;
  assign m1.ar_qos    = s2m.ar_qos;
  assign m1.ar_region = s2m.ar_region;
  assign m1.ar_user   = s2m.ar_user;

  // R from the owning slave only; the other slave is never given ready
  assign r_dn_valid_s = busy_s & (sel_r ? m1.r_valid : m0.r_valid);
  assign r_dn_bus_s   = sel_r ? {m1.r_id, m1.r_data, m1.r_resp, m1.r_last, m1.r_user}
                              : {m0.r_id, m0.r_data, m0.r_resp, m0.r_last, m0.r_user};
  assign m0.r_ready   = busy_s & ~sel_r & r_dn_ready_s;
  assign m1.r_ready   = busy_s &  sel_r & r_dn_ready_s;

`ifdef AXI_MUX_R_RSLICE_EN
  axi_mux_r_slice #(
    .W (R_W)
  ) u_r_slice (
    .clk       (ACLK),
    .rst_n     (ARESETn),
    .in_valid  (r_dn_valid_s),
    .in_ready  (r_dn_ready_s),
    .in_data   (r_dn_bus_s),
    .out_valid (r_up_valid_s),
    .out_ready (s2m.r_ready),
    .out_data  (r_up_bus_s)
  );
`else
  assign r_up_valid_s = r_dn_valid_s;
  assign r_up_bus_s   = r_dn_bus_s;
  assign r_dn_ready_s = s2m.r_ready;
`endif

  // A burst retires when its last beat is handed upstream
  assign r_last_hs_s = r_up_valid_s & s2m.r_ready & r_up_bus_s[LAST_BIT];

  assign s2m.r_valid = r_up_valid_s;
  assign s2m.r_user  = r_up_bus_s[LAST_BIT-1:0];
  assign s2m.r_last  = r_up_bus_s[LAST_BIT];
  assign s2m.r_resp  = r_up_bus_s[DATA_LSB-1:RESP_LSB];
  assign s2m.r_data  = r_up_bus_s[ID_LSB-1:DATA_LSB];
  assign s2m.r_id    = r_up_bus_s[R_W-1:ID_LSB];

  // Outstanding count and ownership state; simultaneous +1/-1 cancel
  always_comb begin
    cnt_nxt_s   = cnt_r;
    state_nxt_s = state_r;
    case ({ar_accept_s, r_last_hs_s})
      2'b10: begin
        cnt_nxt_s = cnt_r + CNT_ONE;
      end
      2'b01: begin
        if (cnt_r != CNT_ZERO) begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      default: begin
        cnt_nxt_s = cnt_r;
      end
    endcase
    case (state_r)
      ST_IDLE: begin
        if (ar_accept_s) begin
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (r_last_hs_s && !ar_accept_s && (cnt_r == CNT_ONE)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, count and owner registers; owner only changes from IDLE
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      sel_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if ((state_r == ST_IDLE) && ar_accept_s) begin
        sel_r <= target_s;
      end else begin
        sel_r <= sel_r;
      end
    end
  end

endmodule

// File: tb/tb_axi_slave_mux_r.sv
// Directed self-checking bench for axi_slave_mux_r.
// Works with and without AXI_MUX_R_RSLICE_EN; R latency expectations follow
// the same macro.  Inputs change on the falling edge, outputs are checked
// one step later, and upstream R beats are logged on the rising edge.
`timescale 1ns/1ps
module tb_axi_slave_mux_r;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int IW = 4;
  localparam int UW = 4;
  localparam int MO = 4;
`ifdef AXI_MUX_R_RSLICE_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  axi_slave_mux_r_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .USER_WIDTH(UW)) s2m_if ();
  axi_slave_mux_r_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .USER_WIDTH(UW)) m0_if ();
  axi_slave_mux_r_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .USER_WIDTH(UW)) m1_if ();

  axi_slave_mux_r #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .USER_WIDTH(UW), .MAX_OUTSTANDING(MO)
  ) dut (
    .ACLK    (clk),
    .ARESETn (rst_n),
    .s2m     (s2m_if),
    .m0      (m0_if),
    .m1      (m1_if)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ar_acc = 0;
  logic [DW-1:0] up_data_q[$];
  logic          up_last_q[$];
  logic [9:0]    up_meta_q[$];
  int            up_cyc_q[$];

  // Upstream R beat log and AR accept counter
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (s2m_if.r_valid && s2m_if.r_ready) begin
      up_data_q.push_back(s2m_if.r_data);
      up_last_q.push_back(s2m_if.r_last);
      up_meta_q.push_back({s2m_if.r_id, s2m_if.r_resp, s2m_if.r_user});
      up_cyc_q.push_back(cyc);
    end
    if (s2m_if.ar_valid && s2m_if.ar_ready) ar_acc <= ar_acc + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ar(input logic v, input logic [AW-1:0] addr, input logic [7:0] len, input logic [IW-1:0] id);
    s2m_if.ar_valid  = v;
    s2m_if.ar_addr   = addr;
    s2m_if.ar_len    = len;
    s2m_if.ar_id     = id;
    s2m_if.ar_size   = 3'd2;
    s2m_if.ar_burst  = 2'b01;
    s2m_if.ar_lock   = 1'b0;
    s2m_if.ar_cache  = 4'h3;
    s2m_if.ar_prot   = 3'd0;
    s2m_if.ar_qos    = 4'h0;
    s2m_if.ar_region = 4'h0;
    s2m_if.ar_user   = 4'h5;
  endtask

  task automatic drive_r(input bit n, input logic v, input logic [DW-1:0] d, input logic l);
    if (n) begin
      m1_if.r_valid = v; m1_if.r_data = d; m1_if.r_last = l;
      m1_if.r_id = 4'h9; m1_if.r_resp = 2'b10; m1_if.r_user = 4'h6;
    end else begin
      m0_if.r_valid = v; m0_if.r_data = d; m0_if.r_last = l;
      m0_if.r_id = 4'h3; m0_if.r_resp = 2'b01; m0_if.r_user = 4'hA;
    end
  endtask

  // Source nbeats on slave n (data base+i) until exp_up beats reached upstream
  task automatic run_r(input bit n, input int nbeats, input logic [DW-1:0] base, input bit tog,
                       input bit all_last, input int last_idx, input int exp_up, output int dn_cyc0);
    int sent = 0;
    int budget = 300;
    int start = up_data_q.size();
    bit hs;
    dn_cyc0 = -1;
    while ((sent < nbeats || (up_data_q.size() - start) < exp_up) && budget > 0) begin
      s2m_if.r_ready = tog ? ~s2m_if.r_ready : 1'b1;
      if (sent < nbeats) drive_r(n, 1'b1, base + DW'(sent), all_last || (sent == last_idx));
      else drive_r(n, 1'b0, '0, 1'b0);
      #1;
      hs = n ? (m1_if.r_valid && m1_if.r_ready) : (m0_if.r_valid && m0_if.r_ready);
      if (hs && sent == 0) dn_cyc0 = cyc;
      @(posedge clk);
      if (hs) sent++;
      @(negedge clk);
      budget--;
    end
    drive_r(n, 1'b0, '0, 1'b0);
    if (budget == 0) check_eq("run_r_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int dn0;
    int a0;
    rst_n = 1'b0;
    set_ar(1'b0, '0, 8'd0, '0);
    s2m_if.r_ready = 1'b0;
    m0_if.ar_ready = 1'b0;
    m1_if.ar_ready = 1'b0;
    drive_r(1'b0, 1'b0, '0, 1'b0);
    drive_r(1'b1, 1'b0, '0, 1'b0);

    // Reset: outputs quiet even with requests and readies present
    repeat (2) @(negedge clk);
    set_ar(1'b1, 32'h0000_0000, 8'd0, 4'h1);
    m0_if.ar_ready = 1'b1;
    drive_r(1'b0, 1'b1, 32'h1234, 1'b1);
    s2m_if.r_ready = 1'b1;
    #1;
    check_eq("rst_arready", s2m_if.ar_ready, 1'b0);
    check_eq("rst_m0_arvalid", m0_if.ar_valid, 1'b0);
    check_eq("rst_rvalid", s2m_if.r_valid, 1'b0);
    check_eq("rst_m0_rready", m0_if.r_ready, 1'b0);
    check_eq("rst_cnt", dut.cnt_r, 3'd0);
    set_ar(1'b0, '0, 8'd0, '0);
    drive_r(1'b0, 1'b0, '0, 1'b0);
    s2m_if.r_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single burst to slave 0, slave 1 kept idle and ignored
    m1_if.ar_ready = 1'b1;
    set_ar(1'b1, 32'h0000_1000, 8'd3, 4'h1);
    #1;
    check_eq("a_arready", s2m_if.ar_ready, 1'b1);
    check_eq("a_m0_arvalid", m0_if.ar_valid, 1'b1);
    check_eq("a_m1_arvalid", m1_if.ar_valid, 1'b0);
    check_eq("a_m1_araddr_fwd", m1_if.ar_addr, 32'h0000_1000);
    check_eq("a_m0_arlen", m0_if.ar_len, 8'd3);
    check_eq("a_m1_arburst", m1_if.ar_burst, 2'b01);
    @(posedge clk); @(negedge clk);
    set_ar(1'b0, '0, 8'd0, '0);
    drive_r(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
    #1;
    check_eq("a_cnt_after_ar", dut.cnt_r, 3'd1);
    check_eq("a_m1_rready", m1_if.r_ready, 1'b0);
    start = up_data_q.size();
    run_r(1'b0, 4, 32'h0000_A000, 1'b0, 1'b0, 3, 4, dn0);
    drive_r(1'b1, 1'b0, '0, 1'b0);
    check_eq("a_beats", up_data_q.size() - start, 4);
    for (int i = 0; i < 4; i++) begin
      check_eq("a_data", up_data_q[start + i], 32'h0000_A000 + i);
      check_eq("a_last", up_last_q[start + i], (i == 3));
    end
    check_eq("a_meta", up_meta_q[start], 10'b0011_01_1010);
    check_eq("a_latency", up_cyc_q[start] - dn0, LAT);
    check_eq("a_cnt_done", dut.cnt_r, 3'd0);
    drive_r(1'b0, 1'b1, 32'h7777, 1'b1);
    #1;
    check_eq("idle_rvalid", s2m_if.r_valid, 1'b0);
    check_eq("idle_m0_rready", m0_if.r_ready, 1'b0);
    drive_r(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);

    // Cross-target stall until the slave 1 burst completes
    set_ar(1'b1, 32'h8000_0000, 8'd1, 4'h2);
    #1;
    check_eq("b_m1_arvalid", m1_if.ar_valid, 1'b1);
    @(posedge clk); @(negedge clk);
    set_ar(1'b1, 32'h0000_0000, 8'd0, 4'h3);
    #1;
    check_eq("b_stall_arready", s2m_if.ar_ready, 1'b0);
    check_eq("b_stall_m0_arvalid", m0_if.ar_valid, 1'b0);
    check_eq("b_stall_m1_arvalid", m1_if.ar_valid, 1'b0);
    a0 = ar_acc;
    start = up_data_q.size();
    run_r(1'b1, 2, 32'h0000_B000, 1'b0, 1'b0, 1, 2, dn0);
    check_eq("b_no_accept_during", ar_acc, a0);
    check_eq("b_beats", up_data_q.size() - start, 2);
    #1;
    check_eq("b_arready_after", s2m_if.ar_ready, 1'b1);
    check_eq("b_m0_arvalid_after", m0_if.ar_valid, 1'b1);
    @(posedge clk); @(negedge clk);
    set_ar(1'b0, '0, 8'd0, '0);
    check_eq("b_cnt", dut.cnt_r, 3'd1);
    check_eq("b_sel", dut.sel_r, 1'b0);
    run_r(1'b0, 1, 32'h0000_B100, 1'b0, 1'b1, 0, 1, dn0);
    check_eq("b_cnt_done", dut.cnt_r, 3'd0);

    // Outstanding limit: five ARs to slave 1, fifth waits for one RLAST
    a0 = ar_acc;
    set_ar(1'b1, 32'h8000_0100, 8'd0, 4'h5);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("c_accepted4", ar_acc - a0, 4);
    check_eq("c_cnt4", dut.cnt_r, 3'd4);
    check_eq("c_arready_full", s2m_if.ar_ready, 1'b0);
    check_eq("c_m1_arvalid_full", m1_if.ar_valid, 1'b0);
    run_r(1'b1, 1, 32'h0000_C000, 1'b0, 1'b1, 0, 1, dn0);
    check_eq("c_still4", ar_acc - a0, 4);
    #1;
    check_eq("c_arready_freed", s2m_if.ar_ready, 1'b1);
    @(posedge clk); @(negedge clk);
    set_ar(1'b0, '0, 8'd0, '0);
    check_eq("c_accepted5", ar_acc - a0, 5);
    check_eq("c_cnt_back4", dut.cnt_r, 3'd4);
    run_r(1'b1, 4, 32'h0000_C100, 1'b0, 1'b1, 0, 4, dn0);
    check_eq("c_cnt_done", dut.cnt_r, 3'd0);

    // Simultaneous AR accept and RLAST handshake at cnt==2
    set_ar(1'b1, 32'h8000_0010, 8'd0, 4'h6);
    @(posedge clk); @(posedge clk); @(negedge clk);
    set_ar(1'b0, '0, 8'd0, '0);
    check_eq("d_cnt2", dut.cnt_r, 3'd2);
    s2m_if.r_ready = 1'b1;
    drive_r(1'b1, 1'b1, 32'h0000_D000, 1'b1);
    if (LAT == 1) begin
      @(posedge clk); @(negedge clk);
      drive_r(1'b1, 1'b0, '0, 1'b0);
    end
    set_ar(1'b1, 32'h8000_0020, 8'd0, 4'h7);
    #1;
    check_eq("d_rlast_up", s2m_if.r_valid & s2m_if.r_last, 1'b1);
    check_eq("d_arready", s2m_if.ar_ready, 1'b1);
    @(posedge clk); @(negedge clk);
    set_ar(1'b0, '0, 8'd0, '0);
    drive_r(1'b1, 1'b0, '0, 1'b0);
    check_eq("d_cnt_same", dut.cnt_r, 3'd2);
    check_eq("d_sel_same", dut.sel_r, 1'b1);
    run_r(1'b1, 2, 32'h0000_D100, 1'b0, 1'b1, 0, 2, dn0);
    check_eq("d_cnt_done", dut.cnt_r, 3'd0);

    // Reset in the middle of a LEN=7 burst
    set_ar(1'b1, 32'h0000_3000, 8'd7, 4'h8);
    @(posedge clk); @(negedge clk);
    set_ar(1'b0, '0, 8'd0, '0);
    run_r(1'b0, 2, 32'h0000_E000, 1'b0, 1'b0, 7, 2, dn0);
    drive_r(1'b0, 1'b1, 32'h0000_E002, 1'b0);
    s2m_if.r_ready = 1'b1;
    set_ar(1'b1, 32'h8000_0000, 8'd0, 4'h9);
    rst_n = 1'b0;
    #1;
    check_eq("e_rst_arready", s2m_if.ar_ready, 1'b0);
    check_eq("e_rst_m1_arvalid", m1_if.ar_valid, 1'b0);
    check_eq("e_rst_m0_rready", m0_if.r_ready, 1'b0);
    check_eq("e_rst_rvalid", s2m_if.r_valid, 1'b0);
    check_eq("e_rst_cnt", dut.cnt_r, 3'd0);
    set_ar(1'b0, '0, 8'd0, '0);
    drive_r(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    m1_if.ar_ready = 1'b0;
    set_ar(1'b1, 32'h8000_0000, 8'd0, 4'h9);
    #1;
    check_eq("e_arready_follows_slave", s2m_if.ar_ready, 1'b0);
    check_eq("e_m1_arvalid", m1_if.ar_valid, 1'b1);
    m1_if.ar_ready = 1'b1;
    #1;
    check_eq("e_arready", s2m_if.ar_ready, 1'b1);
    @(posedge clk); @(negedge clk);
    set_ar(1'b0, '0, 8'd0, '0);
    check_eq("e_cnt1", dut.cnt_r, 3'd1);
    check_eq("e_sel1", dut.sel_r, 1'b1);
    run_r(1'b1, 1, 32'h0000_E100, 1'b0, 1'b1, 0, 1, dn0);
    check_eq("e_cnt_done", dut.cnt_r, 3'd0);

    // Upstream back-pressure toggling every cycle
    set_ar(1'b1, 32'h0000_2000, 8'd7, 4'hA);
    @(posedge clk); @(negedge clk);
    set_ar(1'b0, '0, 8'd0, '0);
    s2m_if.r_ready = 1'b0;
    start = up_data_q.size();
    run_r(1'b0, 8, 32'h0000_F000, 1'b1, 1'b0, 7, 8, dn0);
    check_eq("f_beats", up_data_q.size() - start, 8);
    for (int i = 0; i < 8; i++) begin
      check_eq("f_data", up_data_q[start + i], 32'h0000_F000 + i);
      check_eq("f_last", up_last_q[start + i], (i == 7));
    end
    check_eq("f_cnt_done", dut.cnt_r, 3'd0);
    s2m_if.r_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("f_no_extra_beats", up_data_q.size() - start, 8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
